inst_fetch_queue: RTL and testbench

Front-end fetch stage that sits directly upstream of the instruction decoder. It drives one-outstanding-request fetches to the icache and keeps the PC sequence. Returned instructions are buffered with their PC in a circular queue, and the queue head is presented to the decoder. On a pipeline flush it redirects the PC, drops any in-flight response, and empties the queue.

---
 rtl/inst_fetch_queue.sv | 138 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Fetch stage: one-outstanding icache request, PC sequencing and an 8-entry instruction queue.
// Optional JAL next-PC prediction is enabled by defining FETCH_JAL_PREDICT_EN.
module inst_fetch_queue #(
  parameter int          QUEUE_DEPTH_LOG = 3,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_inst,
  input  logic        deq_ready,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        pred_taken
);

  localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
  localparam logic [QUEUE_DEPTH_LOG-1:0] PTR_ONE = {{(QUEUE_DEPTH_LOG-1){1'b0}}, 1'b1};
  localparam logic [QUEUE_DEPTH_LOG:0]   CNT_ONE = {{QUEUE_DEPTH_LOG{1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                     r_state;
  logic [31:0]                r_fetch_pc;
  logic [QUEUE_DEPTH_LOG-1:0] r_head;
  logic [QUEUE_DEPTH_LOG-1:0] r_tail;
  logic [QUEUE_DEPTH_LOG:0]   r_count;
  logic                       r_discard;
  logic                       r_req_valid;
  logic [31:0]                r_req_addr;

  logic [31:0] r_inst_mem [0:DEPTH-1];
  logic [31:0] r_pc_mem   [0:DEPTH-1];

  logic        w_push;
  logic        w_pop;
  logic [31:0] w_next_pc;
  logic        w_unused_ok;

  assign w_unused_ok = &{1'b0, flush_pc[1:0]};

`ifdef FETCH_JAL_PREDICT_EN
  logic [20:0] w_jal_imm;
  logic        w_is_jal;
  logic        r_pred_mem [0:DEPTH-1];

  assign w_jal_imm = {ic_resp_inst[31], ic_resp_inst[19:12], ic_resp_inst[20],
                      ic_resp_inst[30:21], 1'b0};
  assign w_is_jal  = (ic_resp_inst[6:0] == 7'b1101111);
  assign w_next_pc = w_is_jal ? r_fetch_pc + {{11{w_jal_imm[20]}}, w_jal_imm}
                              : r_fetch_pc + 32'd4;
  assign pred_taken = inst_valid ? r_pred_mem[r_head] : 1'b0;

  always_ff @(posedge clk_in) begin
    if (w_push) r_pred_mem[r_tail] <= w_is_jal;
  end
`else
  assign w_next_pc  = r_fetch_pc + 32'd4;
  assign pred_taken = 1'b0;
`endif

  assign inst_valid   = (r_count != '0);
  // Gate head data so outputs read 0 while empty, including straight out of reset
  assign inst_out     = inst_valid ? r_inst_mem[r_head] : 32'h0;
  assign inst_pc      = inst_valid ? r_pc_mem[r_head]   : 32'h0;
  assign ic_req_valid = r_req_valid & rdy_in;
  assign ic_req_addr  = r_req_addr;

  assign w_pop  = inst_valid && deq_ready && rdy_in && !flush;
  assign w_push = rdy_in && !flush && (r_state == S_WAIT) && ic_resp_valid && !r_discard;

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_inst_mem[r_tail] <= ic_resp_inst;
      r_pc_mem[r_tail]   <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_discard   <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_addr  <= 32'h0;
    end else if (rdy_in) begin
      r_req_valid <= 1'b0;
      if (flush) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_fetch_pc <= {flush_pc[31:2], 2'b00};
        // An in-flight request with no response yet must have its reply swallowed later
        if (r_state == S_WAIT && !ic_resp_valid) begin
          r_discard <= 1'b1;
        end else begin
          r_discard <= 1'b0;
          r_state   <= S_IDLE;
        end
      end else begin
        if (w_push) r_tail <= r_tail + PTR_ONE;
        if (w_pop)  r_head <= r_head + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
        case (r_state)
          S_IDLE: begin
            if (!r_count[QUEUE_DEPTH_LOG]) begin
              r_req_valid <= 1'b1;
              r_req_addr  <= r_fetch_pc;
              r_state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (ic_resp_valid) begin
              r_state   <= S_IDLE;
              r_discard <= 1'b0;
              if (!r_discard) r_fetch_pc <= w_next_pc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: fetch, fill, flush, JAL redirect, stall and PC wrap.
module tb_inst_fetch_queue;

  logic        clk_in;
  logic        rst_n_in;
  logic        rdy_in;
  logic        flush;
  logic [31:0] flush_pc;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_inst;
  logic        deq_ready;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        pred_taken;

  int n_chk = 0;
  int n_err = 0;

`ifdef FETCH_JAL_PREDICT_EN
  localparam logic [31:0] EXP_JAL_NEXT = 32'h18;
  localparam logic [31:0] EXP_JAL_PRED = 32'h1;
`else
  localparam logic [31:0] EXP_JAL_NEXT = 32'h14;
  localparam logic [31:0] EXP_JAL_PRED = 32'h0;
`endif

  inst_fetch_queue #(.QUEUE_DEPTH_LOG(3), .RESET_PC(32'h0)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .ic_req_valid  (ic_req_valid),
    .ic_req_addr   (ic_req_addr),
    .ic_resp_valid (ic_resp_valid),
    .ic_resp_inst  (ic_resp_inst),
    .deq_ready     (deq_ready),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .pred_taken    (pred_taken)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Bounded wait for the next request pulse, then check its address
  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    for (int i = 0; i < 8 && !ic_req_valid; i++) step();
    chk({tag, "_v"}, {31'h0, ic_req_valid}, 32'h1);
    chk({tag, "_a"}, ic_req_addr, exp_addr);
  endtask

  // Wait for the request, answer it one cycle later
  task automatic fetch_one(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    wait_req(tag, exp_addr);
    ic_resp_valid = 1'b1;
    ic_resp_inst  = data;
    step();
    ic_resp_valid = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; flush_pc = 32'h0;
    ic_resp_valid = 1'b0; ic_resp_inst = 32'h0; deq_ready = 1'b1;
    step();
    chk("rst_req_v", {31'h0, ic_req_valid}, 32'h0);
    chk("rst_req_a", ic_req_addr, 32'h0);
    chk("rst_iv", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_pred", {31'h0, pred_taken}, 32'h0);
    rst_n_in = 1'b1;

    // 1: first fetch, icache latency 2
    step();
    chk("t1_req_v", {31'h0, ic_req_valid}, 32'h1);
    chk("t1_req_a", ic_req_addr, 32'h0);
    step();
    chk("t1_pulse", {31'h0, ic_req_valid}, 32'h0);
    ic_resp_valid = 1'b1; ic_resp_inst = 32'h13;
    step();
    ic_resp_valid = 1'b0;
    chk("t1_iv", {31'h0, inst_valid}, 32'h1);
    chk("t1_inst", inst_out, 32'h13);
    chk("t1_pc", inst_pc, 32'h0);
    step();
    chk("t1_req2_v", {31'h0, ic_req_valid}, 32'h1);
    chk("t1_req2_a", ic_req_addr, 32'h4);
    chk("t1_popped", {31'h0, inst_valid}, 32'h0);

    // Async reset mid-WAIT, then a stale response lands in IDLE
    deq_ready = 1'b0;
    rst_n_in = 1'b0;
    #1;
    chk("arst_req_a", ic_req_addr, 32'h0);
    step();
    rst_n_in = 1'b1;
    ic_resp_valid = 1'b1; ic_resp_inst = 32'hBAD;
    step();
    ic_resp_valid = 1'b0;
    chk("stale_iv", {31'h0, inst_valid}, 32'h0);
    chk("stale_req_v", {31'h0, ic_req_valid}, 32'h1);
    chk("stale_req_a", ic_req_addr, 32'h0);

    // 2: fill all 8 entries with deq_ready low
    ic_resp_valid = 1'b1; ic_resp_inst = 32'h1000;
    step();
    ic_resp_valid = 1'b0;
    for (int i = 1; i < 8; i++) fetch_one("t2_fill", 32'(4 * i), 32'h1000 + 32'(i));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_full_noreq", {31'h0, ic_req_valid}, 32'h0);
    end
    chk("t2_head_pc", inst_pc, 32'h0);
    chk("t2_head_inst", inst_out, 32'h1000);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    chk("t2_pop_pc", inst_pc, 32'h4);
    chk("t2_pop_noreq", {31'h0, ic_req_valid}, 32'h0);
    step();
    chk("t2_req_v", {31'h0, ic_req_valid}, 32'h1);
    chk("t2_req_a", ic_req_addr, 32'h20);
    ic_resp_valid = 1'b1; ic_resp_inst = 32'h2000;
    step();
    ic_resp_valid = 1'b0;

    // 6: rdy_in low freezes everything
    rdy_in = 1'b0; deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_req", {31'h0, ic_req_valid}, 32'h0);
      chk("t6_pc", inst_pc, 32'h4);
      chk("t6_inst", inst_out, 32'h1001);
    end
    rdy_in = 1'b1;
    step();
    deq_ready = 1'b0;
    chk("t6_resume_pc", inst_pc, 32'h8);

    // 3: flush while the request to 0x8 is pending, late response dropped
    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    chk("t3_rst_iv", {31'h0, inst_valid}, 32'h0);
    fetch_one("t3_f0", 32'h0, 32'hA0);
    fetch_one("t3_f4", 32'h4, 32'hA4);
    wait_req("t3_req8", 32'h8);
    chk("t3_pre_iv", {31'h0, inst_valid}, 32'h1);
    flush = 1'b1; flush_pc = 32'h103;
    step();
    flush = 1'b0;
    chk("t3_flush_iv", {31'h0, inst_valid}, 32'h0);
    chk("t3_flush_req", {31'h0, ic_req_valid}, 32'h0);
    step();
    step();
    ic_resp_valid = 1'b1; ic_resp_inst = 32'hDEADBEEF;
    step();
    ic_resp_valid = 1'b0;
    chk("t3_drop_iv", {31'h0, inst_valid}, 32'h0);
    chk("t3_drop_req", {31'h0, ic_req_valid}, 32'h0);
    step();
    chk("t3_req_v", {31'h0, ic_req_valid}, 32'h1);
    chk("t3_req_a", ic_req_addr, 32'h100);

    // 4: flush coincident with the response
    ic_resp_valid = 1'b1; ic_resp_inst = 32'h55;
    flush = 1'b1; flush_pc = 32'h102;
    step();
    ic_resp_valid = 1'b0; flush = 1'b0;
    chk("t4_iv", {31'h0, inst_valid}, 32'h0);
    chk("t4_noreq", {31'h0, ic_req_valid}, 32'h0);
    step();
    chk("t4_req_v", {31'h0, ic_req_valid}, 32'h1);
    chk("t4_req_a", ic_req_addr, 32'h100);

    // 5: JAL at 0x10 (offset +8)
    flush = 1'b1; flush_pc = 32'h10;
    step();
    flush = 1'b0;
    ic_resp_valid = 1'b1; ic_resp_inst = 32'h77;
    step();
    ic_resp_valid = 1'b0;
    chk("t5_drop_iv", {31'h0, inst_valid}, 32'h0);
    fetch_one("t5_f10", 32'h10, 32'h0080006F);
    chk("t5_iv", {31'h0, inst_valid}, 32'h1);
    chk("t5_pc", inst_pc, 32'h10);
    chk("t5_inst", inst_out, 32'h0080006F);
    chk("t5_pred", {31'h0, pred_taken}, EXP_JAL_PRED);
    wait_req("t5_next", EXP_JAL_NEXT);

    // PC wraps from 0xFFFFFFFC to 0
    flush = 1'b1; flush_pc = 32'hFFFFFFFE;
    step();
    flush = 1'b0;
    ic_resp_valid = 1'b1; ic_resp_inst = 32'h99;
    step();
    ic_resp_valid = 1'b0;
    fetch_one("wrap_f", 32'hFFFFFFFC, 32'h13);
    chk("wrap_pc", inst_pc, 32'hFFFFFFFC);
    chk("wrap_pred", {31'h0, pred_taken}, 32'h0);
    wait_req("wrap_next", 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
